// File: rtl/reg_file_writeback_pkg.sv
// Shared types for the write-back stage and register file.
// Result-source select, load funct3 codes, buffer state.
package reg_file_writeback_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_e;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/reg_file_writeback_load_extend.sv
// Load data extraction and sign/zero extension.
// Picks byte/halfword lanes out of an aligned memory word.
module load_extend
    import reg_file_writeback_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select; bit 0 of the offset is dropped for halfwords
    always_comb begin
        byte_v = rdata[{offset, 3'b000} +: 8];
        half_v = rdata[{offset[1], 4'b0000} +: 16];
    end

    // Extension by load type; unknown types produce zero
    always_comb begin
        data = '0;
        case (funct3)
            LD_LB:   data = {{(XLEN-8){byte_v[7]}}, byte_v};
            LD_LH:   data = {{(XLEN-16){half_v[15]}}, half_v};
            LD_LW:   data = rdata;
            LD_LBU:  data = {{(XLEN-8){1'b0}}, byte_v};
            LD_LHU:  data = {{(XLEN-16){1'b0}}, half_v};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/reg_file_writeback.sv
// Write-back stage with a one-entry buffer in front of the
// register file; reads bypass the buffered entry.
module reg_file_writeback
    import reg_file_writeback_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            WB_VALID,
    output logic            WB_READY,
    input  logic [4:0]      WB_RD,
    input  logic [1:0]      WB_SEL,
    input  logic [XLEN-1:0] ALU_RESULT,
    input  logic [XLEN-1:0] MEM_RDATA,
    input  logic [2:0]      LOAD_FUNCT3,
    input  logic [1:0]      LOAD_OFFSET,
    input  logic [XLEN-1:0] PC_PLUS4,
    input  logic [XLEN-1:0] IMM,
    input  logic            WB_STALL,
    input  logic [4:0]      READ_Addr_1,
    input  logic [4:0]      READ_Addr_2,
    output logic [XLEN-1:0] READ_Data_1,
    output logic [XLEN-1:0] READ_Data_2,
    output logic [31:0]     RETIRE_COUNT
);

    buf_state_e      state;
    logic [4:0]      buf_rd;
    logic [XLEN-1:0] buf_data;
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wb_data;
    logic            hs;
    logic            commit;

    load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .rdata  (MEM_RDATA),
        .funct3 (LOAD_FUNCT3),
        .offset (LOAD_OFFSET),
        .data   (load_data)
    );

    // Ready unless a stalled entry is still occupying the buffer
    always_comb begin
        WB_READY = (state == EMPTY) || !WB_STALL;
        hs       = WB_VALID && WB_READY;
        commit   = (state == FULL) && !WB_STALL;
    end

    // Result source mux
    always_comb begin
        wb_data = '0;
        unique case (wb_sel_e'(WB_SEL))
            WB_ALU: wb_data = ALU_RESULT;
            WB_MEM: wb_data = load_data;
            WB_PC4: wb_data = PC_PLUS4;
            WB_IMM: wb_data = IMM;
        endcase
    end

    // Buffer: a new request overwrites, otherwise a commit drains it
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= EMPTY;
            buf_rd   <= '0;
            buf_data <= '0;
        end else if (hs) begin
            state    <= FULL;
            buf_rd   <= WB_RD;
            buf_data <= wb_data;
        end else if (commit) begin
            state    <= EMPTY;
        end
    end

    // Architectural array; x0 is never written
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && (buf_rd != '0)
                     && (int'(buf_rd) < NREGS)) begin
            regs[buf_rd] <= buf_data;
        end
    end

    // Retired-write counter, wraps naturally
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            RETIRE_COUNT <= '0;
        end else if (commit) begin
            RETIRE_COUNT <= RETIRE_COUNT + 32'd1;
        end
    end

    // Read port 1: x0, then buffered entry, then array
    always_comb begin
        READ_Data_1 = '0;
        if (READ_Addr_1 == '0) begin
            READ_Data_1 = '0;
        end else if (state == FULL && buf_rd == READ_Addr_1) begin
            READ_Data_1 = buf_data;
        end else if (int'(READ_Addr_1) < NREGS) begin
            READ_Data_1 = regs[READ_Addr_1];
        end
    end

    // Read port 2: x0, then buffered entry, then array
    always_comb begin
        READ_Data_2 = '0;
        if (READ_Addr_2 == '0) begin
            READ_Data_2 = '0;
        end else if (state == FULL && buf_rd == READ_Addr_2) begin
            READ_Data_2 = buf_data;
        end else if (int'(READ_Addr_2) < NREGS) begin
            READ_Data_2 = regs[READ_Addr_2];
        end
    end

endmodule

// File: doc/reg_file_writeback.md
REG_FILE_WRITEBACK -- requirements
Module: reg_file_writeback

Interface
REQ-001 The module SHALL have these parameters, one per line:
  XLEN, 32, datapath width.
  NREGS, 32, architectural register count (x0..x31).
REQ-002 The module SHALL have these ports, one per line:
  CLK  in  1  single clock, rising edge.
  RSTN  in  1  reset; asynchronous, active-low.
  WB_VALID  in  1  write-back request valid.
  WB_READY  out  1  module accepts the request this cycle.
  WB_RD  in  5  destination register.
  WB_SEL  in  2  result source: 00 ALU, 01 MEM, 10 PC+4, 11 IMM.
  ALU_RESULT  in  32  ALU output.
  MEM_RDATA  in  32  raw aligned data memory word.
  LOAD_FUNCT3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  LOAD_OFFSET  in  2  byte address bits [1:0] of the load.
  PC_PLUS4  in  32  return address for JAL/JALR.
  IMM  in  32  immediate for LUI.
  WB_STALL  in  1  inhibits commit of the buffered entry.
  READ_Addr_1  in  5  read port 1 address, from the read-address mux.
  READ_Addr_2  in  5  read port 2 address.
  READ_Data_1  out  32  read port 1 data.
  READ_Data_2  out  32  read port 2 data.
  RETIRE_COUNT  out  32  number of committed writes.

Function
REQ-003 The module SHALL hold one write-back buffer entry (rd, data) with states EMPTY and FULL.
REQ-004 A handshake SHALL occur on a rising edge where WB_VALID=1 and WB_READY=1. The result is selected by WB_SEL and, for MEM, load-extended. The entry is captured in the same edge.
REQ-005 WB_READY SHALL be 1 in EMPTY, and in FULL with WB_STALL=0. It SHALL be 0 in FULL with WB_STALL=1. WB_READY is combinational and independent of WB_VALID.
REQ-006 In FULL with WB_STALL=0, the entry SHALL be written to the array at the next edge. A simultaneous handshake replaces the entry (state stays FULL); with no handshake the state goes to EMPTY.
REQ-007 In EMPTY, a handshake SHALL move the state to FULL. With no handshake the state stays EMPTY.
REQ-008 Load extraction SHALL work as follows:
  - Byte = MEM_RDATA[8*LOAD_OFFSET+:8]; halfword = MEM_RDATA[16*LOAD_OFFSET[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - LOAD_OFFSET[0] is ignored for halfwords and LOAD_OFFSET is ignored for LW.
  - Undefined funct3 values yield 0.
REQ-009 A commit with rd=0 SHALL NOT modify the array, SHALL still increment RETIRE_COUNT, and SHALL empty the buffer.
REQ-010 Read ports SHALL be combinational, as follows:
  - Address 0 returns 0.
  - Else, if FULL and buffered rd equals the address, return the buffered data (bypass).
  - Else return the array contents.
REQ-011 RETIRE_COUNT SHALL increment by 1 on each commit and wrap from 0xFFFFFFFF to 0.
REQ-012 Latency SHALL be: handshake to buffer visible on reads, next cycle; handshake to array write, at earliest the second edge.

Reset
REQ-013 On RSTN low, asynchronously, the module SHALL clear all array registers to 0, set the state to EMPTY, clear the buffer and set RETIRE_COUNT to 0. Outputs then read WB_READY=1 and READ_Data_1/2=0.
REQ-014 Reset asserted while FULL SHALL discard the buffered entry without committing it.
REQ-015 Handshakes and commits SHALL resume on the first rising edge after RSTN deasserts.

Structure
REQ-016 A shared package SHALL hold:
  - the WB_SEL enum (WB_ALU, WB_MEM, WB_PC4, WB_IMM);
  - the load funct3 constants;
  - the buffer state enum (EMPTY, FULL).
REQ-017 Load extraction SHALL be a separate combinational sub-module, load_extend.

Verification
REQ-018 Reset: assert RSTN=0 mid-operation, then release -> all 32 registers read 0, WB_READY=1, RETIRE_COUNT=0.
REQ-019 Write and bypass:
  - Stimulus: handshake WB_RD=5, WB_SEL=ALU, ALU_RESULT=0xDEADBEEF, with READ_Addr_1=5.
  - Next cycle: READ_Data_1=0xDEADBEEF (bypass).
  - After commit: still 0xDEADBEEF from the array; RETIRE_COUNT=1.
REQ-020 Load extension: MEM_RDATA=0x80FF7F01 ->
  - LB offset 2: 0xFFFFFFFF.
  - LBU offset 3: 0x00000080.
  - LH offset 2: 0xFFFF80FF.
  - LHU offset 0: 0x00007F01.
REQ-021 Stall:
  - WB_STALL=1 while FULL -> WB_READY=0, array unchanged, buffer held.
  - WB_STALL=0 -> commit on the next edge and WB_READY=1.
REQ-022 x0 and back-to-back writes:
  - Write rd=0 value 0x1234 -> x0 reads 0, RETIRE_COUNT increments.
  - Consecutive handshakes each cycle to rd=7 with values 1, 2, 3 -> x7 ends at 3, RETIRE_COUNT +3.
